fxp_ops_sequencer: RTL and testbench

//  Time-multiplexes one do_all_ops datapath (Q2.14 op1, Q4.12 op2 -> sum/diff/product/cout/borrow)

---
 rtl/fxp_ops_sequencer_if.sv | 39 +++
 rtl/fxp_ops_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fxp_ops_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_ops_sequencer_if.sv
// Bus bundle between fxp_ops_sequencer and its surroundings.
//   op_*  : operand buffer read port (registered read, data valid next cycle)
//   dp_*  : shared fixed-point datapath (Q2.14 a, Q4.12 b in; sum/diff/mul/cout/borrow out)
//   res_* : result buffer write port (write completes on res_we && res_ready)
// master = sequencer side, slave = memories/datapath side.
interface fxp_ops_sequencer_if #(
    parameter int AW = 8
);
    logic          op_rd_en;
    logic [AW-1:0] op_addr;
    logic [15:0]   op_a;
    logic [15:0]   op_b;
    logic [15:0]   dp_a;
    logic [15:0]   dp_b;
    logic [15:0]   dp_sum;
    logic [15:0]   dp_diff;
    logic [15:0]   dp_mul;
    logic          dp_cout;
    logic          dp_borrow;
    logic          res_we;
    logic          res_ready;
    logic [AW-1:0] res_addr;
    logic [15:0]   res_sum;
    logic [15:0]   res_diff;
    logic [15:0]   res_mul;
    logic          res_cout;
    logic          res_borrow;

    modport master (
        output op_rd_en, op_addr, dp_a, dp_b,
        output res_we, res_addr, res_sum, res_diff, res_mul, res_cout, res_borrow,
        input  op_a, op_b, dp_sum, dp_diff, dp_mul, dp_cout, dp_borrow, res_ready
    );
    modport slave (
        input  op_rd_en, op_addr, dp_a, dp_b,
        input  res_we, res_addr, res_sum, res_diff, res_mul, res_cout, res_borrow,
        output op_a, op_b, dp_sum, dp_diff, dp_mul, dp_cout, dp_borrow, res_ready
    );
endinterface

// File: rtl/fxp_ops_sequencer.sv
// fxp_ops_sequencer: walks NUM_OPS operand pairs through one shared fixed-point
// datapath. Per pair: read operand buffer, load datapath inputs, wait DP_LAT
// cycles, capture results, write them to the result buffer (with back-pressure).
// Ports:
//   clk, rst_n     clock / async active-low reset
//   start          1-cycle pulse, accepted only when idle
//   abort          level, returns to idle at next edge without further writes
//   busy, done     run in progress / 1-cycle pulse after the last write
//   bus            fxp_ops_sequencer_if.master (operand, datapath, result ports)
// Optional build macro FXP_SEQ_STATS_EN adds cout_cnt / borrow_cnt outputs
// counting completed writes whose carry / borrow flag was set.
module fxp_ops_sequencer #(
    parameter int NUM_OPS = 240,
    parameter int AW      = 8,
    parameter int DP_LAT  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    fxp_ops_sequencer_if.master bus
`ifdef FXP_SEQ_STATS_EN
    ,
    output logic [AW:0] cout_cnt,
    output logic [AW:0] borrow_cnt
`endif
);
    localparam int LW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LD, S_WAIT, S_WR, S_DONE} state_t;

    typedef struct packed {
        logic [15:0] sum;
        logic [15:0] diff;
        logic [15:0] mul;
        logic        cout;
        logic        borrow;
    } res_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [15:0]   dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    res_t          res_q, res_d;
    logic          start_acc, wr_fire;

    assign start_acc = (state_q == S_IDLE) && start && !abort;
    assign wr_fire   = (state_q == S_WR) && bus.res_ready && !abort;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        dp_a_d  = dp_a_q;
        dp_b_d  = dp_b_q;
        res_d   = res_q;
        if (abort) begin
            // abort outranks start and res_ready
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_RD;
                    idx_d   = '0;
                end
                S_RD:   state_d = S_LD;
                S_LD: begin
                    // datapath inputs stay frozen from here until the write completes
                    dp_a_d  = bus.op_a;
                    dp_b_d  = bus.op_b;
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (lat_q == LW'(DP_LAT - 1)) begin
                        res_d   = '{sum: bus.dp_sum, diff: bus.dp_diff, mul: bus.dp_mul,
                                    cout: bus.dp_cout, borrow: bus.dp_borrow};
                        state_d = S_WR;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                S_WR: if (bus.res_ready) begin
                    if (idx_q == AW'(NUM_OPS - 1)) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_RD;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            dp_a_q  <= dp_a_d;
            dp_b_q  <= dp_b_d;
            res_q   <= res_d;
        end
    end

    assign busy           = (state_q == S_RD) || (state_q == S_LD) ||
                            (state_q == S_WAIT) || (state_q == S_WR);
    assign done           = (state_q == S_DONE);
    assign bus.op_rd_en   = (state_q == S_RD);
    assign bus.op_addr    = idx_q;
    assign bus.dp_a       = dp_a_q;
    assign bus.dp_b       = dp_b_q;
    assign bus.res_we     = (state_q == S_WR);
    assign bus.res_addr   = idx_q;
    assign bus.res_sum    = res_q.sum;
    assign bus.res_diff   = res_q.diff;
    assign bus.res_mul    = res_q.mul;
    assign bus.res_cout   = res_q.cout;
    assign bus.res_borrow = res_q.borrow;

`ifdef FXP_SEQ_STATS_EN
    localparam int CW = AW + 1;
    logic [AW:0] cout_cnt_q, cout_cnt_d, borrow_cnt_q, borrow_cnt_d;

    always_comb begin
        cout_cnt_d   = cout_cnt_q;
        borrow_cnt_d = borrow_cnt_q;
        if (start_acc) begin
            cout_cnt_d   = '0;
            borrow_cnt_d = '0;
        end else if (wr_fire) begin
            cout_cnt_d   = cout_cnt_q + CW'(res_q.cout);
            borrow_cnt_d = borrow_cnt_q + CW'(res_q.borrow);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_cnt_q   <= '0;
            borrow_cnt_q <= '0;
        end else begin
            cout_cnt_q   <= cout_cnt_d;
            borrow_cnt_q <= borrow_cnt_d;
        end
    end

    assign cout_cnt   = cout_cnt_q;
    assign borrow_cnt = borrow_cnt_q;
`else
    // start_acc / wr_fire only feed the statistics counters
    logic unused_stats;
    assign unused_stats = start_acc ^ wr_fire;
`endif
endmodule

// File: tb/tb_fxp_ops_sequencer.sv
module tb_fxp_ops_sequencer;
    localparam int AW = 8;
    localparam int N  = 240;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start240, abort240, busy240, done240;
    logic start4, abort4, busy4, done4;
    int   checks = 0, errors = 0, ecnt = 0, t240 = 0, t4 = 0;
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [57:0] q4 [$];

    fxp_ops_sequencer_if #(.AW(AW)) b240 ();
    fxp_ops_sequencer_if #(.AW(AW)) b4 ();
`ifdef FXP_SEQ_STATS_EN
    logic [AW:0] cc240, bc240, cc4, bc4;
`endif

    fxp_ops_sequencer #(.NUM_OPS(N), .AW(AW), .DP_LAT(1)) u240 (
        .clk(clk), .rst_n(rst_n), .start(start240), .abort(abort240),
        .busy(busy240), .done(done240), .bus(b240)
`ifdef FXP_SEQ_STATS_EN
        , .cout_cnt(cc240), .borrow_cnt(bc240)
`endif
    );
    fxp_ops_sequencer #(.NUM_OPS(4), .AW(AW), .DP_LAT(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .bus(b4)
`ifdef FXP_SEQ_STATS_EN
        , .cout_cnt(cc4), .borrow_cnt(bc4)
`endif
    );

    // reference datapath: {sum, diff, mul(Q4.12), cout, borrow}
    function automatic logic [49:0] dp_f(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s, d;
        logic signed [31:0] p;
        s = {1'b0, a} + {1'b0, b};
        d = {1'b0, a} - {1'b0, b};
        p = $signed(a) * $signed(b);
        return {s[15:0], d[15:0], p[29:14], s[16], d[16]};
    endfunction

    assign {b240.dp_sum, b240.dp_diff, b240.dp_mul, b240.dp_cout, b240.dp_borrow} = dp_f(b240.dp_a, b240.dp_b);
    assign {b4.dp_sum, b4.dp_diff, b4.dp_mul, b4.dp_cout, b4.dp_borrow} = dp_f(b4.dp_a, b4.dp_b);

    always @(posedge clk) begin
        if (b240.op_rd_en) begin
            b240.op_a <= mem_a[b240.op_addr];
            b240.op_b <= mem_b[b240.op_addr];
        end
        if (b4.op_rd_en) begin
            b4.op_a <= mem_a[b4.op_addr];
            b4.op_b <= mem_b[b4.op_addr];
        end
        ecnt <= ecnt + 1;
    end

    always @(negedge clk)
        if (rst_n && b4.res_we && b4.res_ready)
            q4.push_back({b4.res_addr, b4.res_sum, b4.res_diff, b4.res_mul, b4.res_cout, b4.res_borrow});

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // model of the 240-pair run: which index is due next and whether a run is live
    logic m_run, m_done;
    int   m_idx, m_wr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_done <= 1'b0; m_idx <= 0; m_wr <= 0;
        end else begin
            m_done <= 1'b0;
            if (abort240) m_run <= 1'b0;
            else if (!m_run && !m_done && start240) begin
                m_run <= 1'b1; m_idx <= 0; m_wr <= 0;
            end else if (m_run && b240.res_we && b240.res_ready) begin
                m_wr  <= m_wr + 1;
                m_idx <= m_idx + 1;
                if (m_idx == N - 1) begin
                    m_run <= 1'b0; m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy240, m_run);
            chk("done", done240, m_done);
            if (b240.op_rd_en) begin
                chk("rd_in_run", m_run, 1);
                chk("op_addr", b240.op_addr, m_idx);
            end
            if (b240.res_we) begin
                chk("we_in_run", m_run, 1);
                chk("res_addr", b240.res_addr, m_idx);
                chk("res_data", {b240.res_sum, b240.res_diff, b240.res_mul, b240.res_cout, b240.res_borrow},
                    dp_f(mem_a[m_idx[7:0]], mem_b[m_idx[7:0]]));
                chk("dp_hold", {b240.dp_a, b240.dp_b}, {mem_a[m_idx[7:0]], mem_b[m_idx[7:0]]});
                if (m_idx == 5)
                    chk("res5_lit", {b240.res_sum, b240.res_diff, b240.res_mul, b240.res_cout, b240.res_borrow},
                        {16'hB000, 16'hD000, 16'h1000, 1'b1, 1'b1});
            end
        end
    end

    task automatic go240;
        @(negedge clk) start240 = 1'b1;
        @(negedge clk) start240 = 1'b0;
        t240 = ecnt;
    endtask
    task automatic go4;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        t4 = ecnt;
    endtask
    task automatic wait240(output int n);
        int k = 0;
        while (!done240 && k < 3000) begin @(negedge clk); k++; end
        chk("done240_seen", done240, 1);
        n = ecnt - t240;
    endtask
    task automatic wait4(output int n);
        int k = 0;
        while (!done4 && k < 200) begin @(negedge clk); k++; end
        chk("done4_seen", done4, 1);
        n = ecnt - t4;
    endtask

    initial begin
        int n, k, w;
        rst_n = 1'b0; start240 = 1'b0; abort240 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
        b240.res_ready = 1'b1; b4.res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h4000; mem_b[i] = 16'h1000; end
        #12;
        chk("rst_ctl", {busy240, done240, b240.op_rd_en, b240.res_we}, 0);
        chk("rst_addr", {b240.op_addr, b240.res_addr}, 0);
        chk("rst_dp", {b240.dp_a, b240.dp_b}, 0);
        chk("rst_res", {b240.res_sum, b240.res_diff, b240.res_mul, b240.res_cout, b240.res_borrow}, 0);
        @(negedge clk) rst_n = 1'b1;

        // 4-pair run with hand-computed results
        go4;
        wait4(n);
        chk("run4_cycles", n, 16);
        chk("run4_writes", q4.size(), 4);
        for (int i = 0; i < 4 && i < q4.size(); i++)
            chk("run4_entry", q4[i], {8'(i), 16'h5000, 16'h3000, 16'h1000, 1'b0, 1'b0});
        @(negedge clk);
        chk("run4_idle", {busy4, done4}, 0);

        // full run with a spurious start mid-run
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'(i * 16'h0137 + 16'h02b1);
            mem_b[i] = 16'(i * 16'h0a31) ^ 16'hc3c5;
        end
        mem_a[5] = 16'hC000; mem_b[5] = 16'hF000;
        go240;
        repeat (100) @(negedge clk);
        start240 = 1'b1;
        @(negedge clk) start240 = 1'b0;
        wait240(n);
        chk("run240_cycles", n, 960);
        chk("run240_writes", m_wr, 240);

        // back-pressure during WR of idx 2
        go240;
        k = 0;
        while (!(b240.res_we && b240.res_addr == 8'd2) && k < 100) begin @(negedge clk); k++; end
        chk("stall_found", {b240.res_we, b240.res_addr}, {1'b1, 8'd2});
        b240.res_ready = 1'b0;
        repeat (5) @(negedge clk);
        b240.res_ready = 1'b1;
        wait240(n);
        chk("stall_cycles", n, 965);
        chk("stall_writes", m_wr, 240);

        // abort in WAIT of idx 10
        go240;
        k = 0;
        while (!(b240.op_rd_en && b240.op_addr == 8'd10) && k < 100) begin @(negedge clk); k++; end
        chk("abort_found", {b240.op_rd_en, b240.op_addr}, {1'b1, 8'd10});
        @(negedge clk);
        @(negedge clk) abort240 = 1'b1;
        @(negedge clk) abort240 = 1'b0;
        chk("abort_busy", busy240, 0);
        w = 0;
        repeat (30) begin @(negedge clk); if (b240.res_we || done240) w++; end
        chk("abort_quiet", w, 0);
        chk("abort_writes", m_wr, 10);
        go240;
        wait240(n);
        chk("restart_cycles", n, 960);

        // asynchronous reset mid-run
        go240;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_ctl", {busy240, b240.res_we, b240.op_rd_en}, 0);
        chk("areset_addr", {b240.op_addr, b240.res_addr}, 0);
        @(negedge clk) rst_n = 1'b1;

`ifdef FXP_SEQ_STATS_EN
        mem_a[0] = 16'hC000; mem_b[0] = 16'hF000;
        mem_a[1] = 16'h4000; mem_b[1] = 16'h1000;
        mem_a[2] = 16'h8000; mem_b[2] = 16'h8000;
        mem_a[3] = 16'hFFFF; mem_b[3] = 16'h0001;
        go4;
        wait4(n);
        @(negedge clk);
        chk("cout_cnt", cc4, 3);
        chk("borrow_cnt", bc4, 1);
        go4;
        chk("cnt_clear", {cc4, bc4}, 0);
        wait4(n);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
